// File: rtl/pll_reset_sequencer_if.sv
// Control bundle between the PLL reset supervisor and the logic around it.
// Latency: none; plain wires grouped for port hygiene.
// Backpressure: none; every signal is a free-running level.
//
// Signals:
//   locked       PLL lock indication, asynchronous to the sequencer clock
//   req_reset    synchronous active-high soft reset request (level)
//   pll_rst      active-high reset pulse towards the PLL
//   mem_reset_n  active-low reset for SDRAM controller / clock-crossing logic
//   core_reset_n active-low reset for the core
//   ready        high once the release sequence has completed
// The master modport is the sequencer; the slave modport is its surroundings.
interface pll_reset_sequencer_if;
  logic locked;
  logic req_reset;
  logic pll_rst;
  logic mem_reset_n;
  logic core_reset_n;
  logic ready;

  modport master (
    input  locked,
    input  req_reset,
    output pll_rst,
    output mem_reset_n,
    output core_reset_n,
    output ready
  );

  modport slave (
    output locked,
    output req_reset,
    input  pll_rst,
    input  mem_reset_n,
    input  core_reset_n,
    input  ready
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Reset supervisor: waits for stable PLL lock, releases memory then core reset, pulses PLL reset on timeout.
// Latency: mem_reset_n rises SYNC_STAGES+LOCK_CYCLES edges after lock; core_reset_n/ready STAGE_GAP edges later.
// Backpressure: none; lock loss or req_reset re-asserts resets regardless of downstream state.
//
// Ports:
//   clk      free-running reference clock (PLL input clock, not a PLL output)
//   reset_n  asynchronous active-low reset; forces all outputs to their reset values
//   ctl      control bundle (master side): locked, req_reset in; pll_rst,
//            mem_reset_n, core_reset_n, ready out (all outputs registered)
module pll_reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int LOCK_CYCLES    = 1024,
  parameter int STAGE_GAP      = 16,
  parameter int RELOCK_TIMEOUT = 1048576,
  parameter int PLL_RST_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pll_reset_sequencer_if.master ctl
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXP = max2(max2(max2(LOCK_CYCLES, STAGE_GAP),
                                  max2(RELOCK_TIMEOUT, PLL_RST_CYCLES)),
                             SYNC_STAGES);
  localparam int CW   = $clog2(MAXP) + 1;

  // Terminal counts: the transition happens on the edge where the counter
  // already holds the last value, so the state lasts exactly N edges.
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(RELOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] PR_LAST   = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    PLL_RST,
    STABLE,
    GAP,
    RUN
  } state_t;

  state_t                 state_q, state_nxt;
  logic [CW-1:0]          cnt_q, cnt_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic                   pll_rst_q, mem_reset_n_q, core_reset_n_q, ready_q;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CNT_ONE;
  endfunction

  // Lock synchroniser: locked is asynchronous to clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ctl.locked};
    end
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // One shared counter: timeout in WAIT_LOCK, pulse width in PLL_RST,
  // lock qualification in STABLE, release spacing in GAP.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    unique case (state_q)
      WAIT_LOCK: begin
        if (locked_s) begin
          // The edge that first sees lock already counts as one qualified
          // lock cycle, unless a soft reset request is holding the count.
          if (req_reset_active() || LOCK_CYCLES > 1) begin
            state_nxt = STABLE;
            cnt_nxt   = req_reset_active() ? '0 : CNT_ONE;
          end else begin
            state_nxt = GAP;
            cnt_nxt   = '0;
          end
        end else if (req_reset_active()) begin
          cnt_nxt = cnt_q;
        end else if (cnt_q >= TO_LAST) begin
          state_nxt = PLL_RST;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = sat_inc(cnt_q);
        end
      end
      PLL_RST: begin
        // Lock status and soft requests are ignored so the PLL always
        // receives a full-width reset pulse.
        if (cnt_q >= PR_LAST) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = sat_inc(cnt_q);
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (req_reset_active()) begin
          cnt_nxt = '0;
        end else if (cnt_q >= LOCK_LAST) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = sat_inc(cnt_q);
        end
      end
      GAP: begin
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (req_reset_active()) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else if (cnt_q >= GAP_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = sat_inc(cnt_q);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (req_reset_active()) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = WAIT_LOCK;
        cnt_nxt   = '0;
      end
    endcase
  end

  function automatic logic req_reset_active();
    return ctl.req_reset;
  endfunction

  // Outputs are a registered decode of the next state, so they change on the
  // same edge as the state and core release can never precede memory release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pll_rst_q      <= 1'b0;
      mem_reset_n_q  <= 1'b0;
      core_reset_n_q <= 1'b0;
      ready_q        <= 1'b0;
    end else begin
      pll_rst_q      <= (state_nxt == PLL_RST);
      mem_reset_n_q  <= (state_nxt == GAP) || (state_nxt == RUN);
      core_reset_n_q <= (state_nxt == RUN);
      ready_q        <= (state_nxt == RUN);
    end
  end

  assign ctl.pll_rst      = pll_rst_q;
  assign ctl.mem_reset_n  = mem_reset_n_q;
  assign ctl.core_reset_n = core_reset_n_q;
  assign ctl.ready        = ready_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short parameters.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: not applicable; stimulus is a fixed linear sequence.
module tb_pll_reset_sequencer;

  logic clk;
  logic reset_n;
  int   tests;
  int   fails;

  pll_reset_sequencer_if ctl();

  pll_reset_sequencer #(
    .SYNC_STAGES   (2),
    .LOCK_CYCLES   (8),
    .STAGE_GAP     (4),
    .RELOCK_TIMEOUT(32),
    .PLL_RST_CYCLES(3)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .ctl    (ctl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int e, input logic obs, input logic exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, e, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int e, input logic p,
                         input logic m, input logic c, input logic r);
    chk({tag, ".pll_rst"}, e, ctl.pll_rst, p);
    chk({tag, ".mem_reset_n"}, e, ctl.mem_reset_n, m);
    chk({tag, ".core_reset_n"}, e, ctl.core_reset_n, c);
    chk({tag, ".ready"}, e, ctl.ready, r);
  endtask

  // Lock already stable: run n edges, memory released at edge mem_at,
  // core/ready at edge core_at (edges counted from the frame start).
  task automatic release_seq(input string tag, input int n, input int mem_at, input int core_at);
    for (int e = 1; e <= n; e++) begin
      tick();
      chk_all(tag, e, 1'b0, e >= mem_at, e >= core_at, e >= core_at);
    end
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    reset_n       = 1'b0;
    ctl.locked    = 1'b1;
    ctl.req_reset = 1'b0;

    // Reset state.
    repeat (3) tick();
    chk_all("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Power-up with lock already present: mem at edge 10, core/ready at 14.
    reset_n = 1'b1;
    release_seq("powerup", 16, 10, 14);

    // Lock loss in RUN: locked falls before edge k, outputs low at k+2.
    ctl.locked = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk_all("lockloss", e, 1'b0, e < 3, e < 3, e < 3);
    end
    // Relock: identical latencies to power-up.
    ctl.locked = 1'b1;
    release_seq("relock", 15, 10, 14);

    // One-cycle soft reset in RUN.
    ctl.req_reset = 1'b1;
    tick();
    chk_all("req_edge", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    ctl.req_reset = 1'b0;
    release_seq("req_release", 13, 8, 12);

    // Captured lock glitch during STABLE restarts qualification.
    ctl.locked = 1'b0;
    repeat (4) tick();
    chk_all("pre_glitch", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    ctl.locked = 1'b1;
    for (int e = 1; e <= 21; e++) begin
      tick();
      chk_all("glitch", e, 1'b0, e >= 16, e >= 20, e >= 20);
      if (e == 5) ctl.locked = 1'b0;
      if (e == 6) ctl.locked = 1'b1;
    end

    // Asynchronous reset in the middle of GAP.
    ctl.req_reset = 1'b1;
    tick();
    ctl.req_reset = 1'b0;
    repeat (9) tick();
    chk_all("gap_before_arst", 9, 1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("arst_async", 9, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    chk_all("arst_held", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    release_seq("after_arst", 15, 10, 14);

    // No lock at all: pll_rst high 3 of every 35 edges, first rise at 32.
    reset_n    = 1'b0;
    ctl.locked = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    for (int e = 1; e <= 106; e++) begin
      tick();
      chk("nolock.pll_rst", e, ctl.pll_rst, (e % 35) >= 32);
      chk("nolock.mem_reset_n", e, ctl.mem_reset_n, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
